// File: rtl/frame_pair_aligner.sv
// Locks a previous-frame and a current-frame AXI-Stream pair onto a common start of frame,
// then forwards them beat-locked through one shared output slot while checking frame geometry.
module frame_pair_aligner #(
    parameter int DATA_WIDTH = 32,
    parameter int H_ACTIVE   = 1920,
    parameter int V_ACTIVE   = 1080
) (
    input  logic                  aclk,
    input  logic                  aresetn,

    input  logic [DATA_WIDTH-1:0] s_prev_axis_tdata,
    input  logic                  s_prev_axis_tvalid,
    output logic                  s_prev_axis_tready,
    input  logic                  s_prev_axis_tlast,
    input  logic                  s_prev_axis_tuser,

    input  logic [DATA_WIDTH-1:0] s_curr_axis_tdata,
    input  logic                  s_curr_axis_tvalid,
    output logic                  s_curr_axis_tready,
    input  logic                  s_curr_axis_tlast,
    input  logic                  s_curr_axis_tuser,

    output logic [DATA_WIDTH-1:0] m_prev_axis_tdata,
    output logic                  m_prev_axis_tvalid,
    input  logic                  m_prev_axis_tready,
    output logic                  m_prev_axis_tlast,
    output logic                  m_prev_axis_tuser,

    output logic [DATA_WIDTH-1:0] m_curr_axis_tdata,
    output logic                  m_curr_axis_tvalid,
    input  logic                  m_curr_axis_tready,
    output logic                  m_curr_axis_tlast,
    output logic                  m_curr_axis_tuser,

    output logic                  frame_locked,
    output logic [15:0]           err_count,
    output logic                  err_sticky
);

    localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

    localparam logic [0:0] SEEK = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [XW-1:0]         x_q, x_d;
    logic [YW-1:0]         y_q, y_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] prev_data_q, prev_data_d;
    logic [DATA_WIDTH-1:0] curr_data_q, curr_data_d;
    logic                  prev_last_q, prev_last_d;
    logic                  curr_last_q, curr_last_d;
    logic                  prev_user_q, prev_user_d;
    logic                  curr_user_q, curr_user_d;
    logic [15:0]           err_count_q, err_count_d;
    logic                  err_sticky_q, err_sticky_d;

    logic slot_free;
    logic at_origin;
    logic at_line_end;
    logic prev_sof;
    logic curr_sof;
    logic tuser_err;
    logic tlast_err;
    logic pair_fire;
    logic err_event;

    always_comb begin
        slot_free   = !out_valid_q || (m_prev_axis_tready && m_curr_axis_tready);
        at_origin   = (x_q == '0) && (y_q == '0);
        at_line_end = (x_q == X_LAST);
        prev_sof    = s_prev_axis_tvalid && s_prev_axis_tuser;
        curr_sof    = s_curr_axis_tvalid && s_curr_axis_tuser;

        // At the frame origin a start-of-frame is expected, but only a disagreement between the
        // two streams is an error; anywhere else any start-of-frame marker is out of place.
        tuser_err = 1'b0;
        if (state_q == RUN) begin
            if (!at_origin) begin
                tuser_err = prev_sof || curr_sof;
            end else begin
                tuser_err = s_prev_axis_tvalid && s_curr_axis_tvalid
                            && (s_prev_axis_tuser != s_curr_axis_tuser);
            end
        end

        pair_fire = (state_q == RUN) && s_prev_axis_tvalid && s_curr_axis_tvalid
                    && slot_free && !tuser_err;
        tlast_err = pair_fire && ((s_prev_axis_tlast != at_line_end)
                                  || (s_curr_axis_tlast != at_line_end));
        err_event = tuser_err || tlast_err;
    end

    // Ready is forced low during reset since it is a combinational output.
    always_comb begin
        s_prev_axis_tready = 1'b0;
        s_curr_axis_tready = 1'b0;
        if (aresetn) begin
            if (state_q == SEEK) begin
                s_prev_axis_tready = s_prev_axis_tvalid && !s_prev_axis_tuser;
                s_curr_axis_tready = s_curr_axis_tvalid && !s_curr_axis_tuser;
            end else begin
                s_prev_axis_tready = pair_fire;
                s_curr_axis_tready = pair_fire;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        if (state_q == SEEK) begin
            if (prev_sof && curr_sof) begin
                state_d = RUN;
                x_d     = '0;
                y_d     = '0;
            end
        end else if (err_event) begin
            state_d = SEEK;
        end else if (pair_fire) begin
            if (at_line_end) begin
                x_d = '0;
                y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        prev_data_d = prev_data_q;
        curr_data_d = curr_data_q;
        prev_last_d = prev_last_q;
        curr_last_d = curr_last_q;
        prev_user_d = prev_user_q;
        curr_user_d = curr_user_q;
        if (pair_fire) begin
            out_valid_d = 1'b1;
            prev_data_d = s_prev_axis_tdata;
            curr_data_d = s_curr_axis_tdata;
            prev_last_d = s_prev_axis_tlast;
            curr_last_d = s_curr_axis_tlast;
            prev_user_d = s_prev_axis_tuser;
            curr_user_d = s_curr_axis_tuser;
        end else if (out_valid_q && m_prev_axis_tready && m_curr_axis_tready) begin
            out_valid_d = 1'b0;
        end
    end

    always_comb begin
        err_count_d  = err_count_q;
        err_sticky_d = err_sticky_q;
        if (err_event) begin
            if (err_count_q != 16'hFFFF) begin
                err_count_d = err_count_q + 16'd1;
            end
            err_sticky_d = 1'b1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= SEEK;
            x_q          <= '0;
            y_q          <= '0;
            out_valid_q  <= 1'b0;
            prev_data_q  <= '0;
            curr_data_q  <= '0;
            prev_last_q  <= 1'b0;
            curr_last_q  <= 1'b0;
            prev_user_q  <= 1'b0;
            curr_user_q  <= 1'b0;
            err_count_q  <= '0;
            err_sticky_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            out_valid_q  <= out_valid_d;
            prev_data_q  <= prev_data_d;
            curr_data_q  <= curr_data_d;
            prev_last_q  <= prev_last_d;
            curr_last_q  <= curr_last_d;
            prev_user_q  <= prev_user_d;
            curr_user_q  <= curr_user_d;
            err_count_q  <= err_count_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    assign m_prev_axis_tvalid = out_valid_q;
    assign m_curr_axis_tvalid = out_valid_q;
    assign m_prev_axis_tdata  = prev_data_q;
    assign m_curr_axis_tdata  = curr_data_q;
    assign m_prev_axis_tlast  = prev_last_q;
    assign m_curr_axis_tlast  = curr_last_q;
    assign m_prev_axis_tuser  = prev_user_q;
    assign m_curr_axis_tuser  = curr_user_q;

    assign frame_locked = (state_q == RUN);
    assign err_count    = err_count_q;
    assign err_sticky   = err_sticky_q;

endmodule

// File: tb/tb_frame_pair_aligner.sv
// Bench for frame_pair_aligner: SEEK ready table, directed alignment/error/reset sequences and
// randomized streams compared against a sequence-level model of the pairing rules.
`timescale 1ns/1ps
module tb_frame_pair_aligner;

    localparam int DW = 32;
    localparam int H  = 8;
    localparam int V  = 4;

    logic          clk = 1'b0;
    logic          aresetn;
    logic [DW-1:0] s_prev_axis_tdata, s_curr_axis_tdata;
    logic          s_prev_axis_tvalid, s_prev_axis_tready, s_prev_axis_tlast, s_prev_axis_tuser;
    logic          s_curr_axis_tvalid, s_curr_axis_tready, s_curr_axis_tlast, s_curr_axis_tuser;
    logic [DW-1:0] m_prev_axis_tdata, m_curr_axis_tdata;
    logic          m_prev_axis_tvalid, m_prev_axis_tready, m_prev_axis_tlast, m_prev_axis_tuser;
    logic          m_curr_axis_tvalid, m_curr_axis_tready, m_curr_axis_tlast, m_curr_axis_tuser;
    logic          frame_locked;
    logic [15:0]   err_count;
    logic          err_sticky;

    always #5 clk = ~clk;

    frame_pair_aligner #(.DATA_WIDTH(DW), .H_ACTIVE(H), .V_ACTIVE(V)) dut (
        .aclk(clk), .aresetn(aresetn),
        .s_prev_axis_tdata(s_prev_axis_tdata), .s_prev_axis_tvalid(s_prev_axis_tvalid),
        .s_prev_axis_tready(s_prev_axis_tready), .s_prev_axis_tlast(s_prev_axis_tlast),
        .s_prev_axis_tuser(s_prev_axis_tuser),
        .s_curr_axis_tdata(s_curr_axis_tdata), .s_curr_axis_tvalid(s_curr_axis_tvalid),
        .s_curr_axis_tready(s_curr_axis_tready), .s_curr_axis_tlast(s_curr_axis_tlast),
        .s_curr_axis_tuser(s_curr_axis_tuser),
        .m_prev_axis_tdata(m_prev_axis_tdata), .m_prev_axis_tvalid(m_prev_axis_tvalid),
        .m_prev_axis_tready(m_prev_axis_tready), .m_prev_axis_tlast(m_prev_axis_tlast),
        .m_prev_axis_tuser(m_prev_axis_tuser),
        .m_curr_axis_tdata(m_curr_axis_tdata), .m_curr_axis_tvalid(m_curr_axis_tvalid),
        .m_curr_axis_tready(m_curr_axis_tready), .m_curr_axis_tlast(m_curr_axis_tlast),
        .m_curr_axis_tuser(m_curr_axis_tuser),
        .frame_locked(frame_locked), .err_count(err_count), .err_sticky(err_sticky)
    );

    typedef struct packed { logic [DW-1:0] data; logic user; logic last; } beat_t;
    typedef struct packed { beat_t p; beat_t c; } pair_t;
    typedef struct { logic pv; logic pu; logic cv; logic cu; logic exp_pr; logic exp_cr; } seek_vec_t;

    int    checks = 0;
    int    failures = 0;
    beat_t sp_q[$], sc_q[$], mp_q[$], mc_q[$];
    pair_t out_log[$], exp_q[$];
    logic  lock_log[$], pr_log[$], bp_pat[$];
    int    exp_err = 0;
    int    vpct = 100, rpct = 100;
    logic  p_pres = 1'b0, c_pres = 1'b0;
    logic  have_stall = 1'b0;
    beat_t snap_p, snap_c;
    int    cyc_idx = 0;
    logic  progress;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push_beat(input int strm, input logic user, input logic last);
        beat_t b;
        b.data = $urandom;
        b.user = user;
        b.last = last;
        if (strm == 0) sp_q.push_back(b);
        else           sc_q.push_back(b);
    endtask

    // n beats of a well-formed frame; short_at >= 0 puts the only tlast at that beat
    task automatic push_frame(input int strm, input int n, input int short_at);
        for (int i = 0; i < n; i++) begin
            push_beat(strm, i == 0, (short_at >= 0) ? (i == short_at) : ((i % H) == H - 1));
        end
    endtask

    task automatic push_junk(input int strm, input int n);
        for (int i = 0; i < n; i++) push_beat(strm, 1'b0, 1'($urandom_range(1)));
    endtask

    // Sequence-level model: drop to SOF on each stream, then pair beats while checking geometry.
    function automatic void model_run();
        bit    locked, hp, hc, origin, eol;
        int    x, y;
        pair_t pr;
        locked = 0; x = 0; y = 0;
        for (int guard = 0; guard < 100000; guard++) begin
            if (!locked) begin
                while (mp_q.size() > 0 && !mp_q[0].user) void'(mp_q.pop_front());
                while (mc_q.size() > 0 && !mc_q[0].user) void'(mc_q.pop_front());
                if (mp_q.size() == 0 || mc_q.size() == 0) break;
                locked = 1; x = 0; y = 0;
            end else begin
                hp = mp_q.size() > 0;
                hc = mc_q.size() > 0;
                origin = (x == 0) && (y == 0);
                if (!origin && ((hp && mp_q[0].user) || (hc && mc_q[0].user))) begin
                    exp_err++; locked = 0;
                end else if (!hp || !hc) begin
                    break;
                end else if (origin && (mp_q[0].user != mc_q[0].user)) begin
                    exp_err++; locked = 0;
                end else begin
                    pr.p = mp_q.pop_front();
                    pr.c = mc_q.pop_front();
                    exp_q.push_back(pr);
                    eol = (x == H - 1);
                    if (pr.p.last != eol || pr.c.last != eol) begin
                        exp_err++; locked = 0;
                    end else begin
                        x++;
                        if (x == H) begin x = 0; y++; if (y == V) y = 0; end
                    end
                end
            end
        end
    endfunction

    task automatic cycle();
        logic  p_acc, c_acc, both_rdy, fire_out;
        beat_t mp, mc;
        pair_t pr;
        @(negedge clk);
        if (!p_pres && sp_q.size() > 0 && $urandom_range(99) < vpct) p_pres = 1'b1;
        if (!c_pres && sc_q.size() > 0 && $urandom_range(99) < vpct) c_pres = 1'b1;
        s_prev_axis_tvalid = p_pres;
        {s_prev_axis_tdata, s_prev_axis_tuser, s_prev_axis_tlast} = p_pres ? sp_q[0] : '0;
        s_curr_axis_tvalid = c_pres;
        {s_curr_axis_tdata, s_curr_axis_tuser, s_curr_axis_tlast} = c_pres ? sc_q[0] : '0;
        if (bp_pat.size() > 0) begin
            m_prev_axis_tready = 1'b1;
            m_curr_axis_tready = bp_pat[cyc_idx % bp_pat.size()];
        end else begin
            m_prev_axis_tready = ($urandom_range(99) < rpct);
            m_curr_axis_tready = ($urandom_range(99) < rpct);
        end
        #4;
        p_acc    = s_prev_axis_tvalid && s_prev_axis_tready;
        c_acc    = s_curr_axis_tvalid && s_curr_axis_tready;
        both_rdy = m_prev_axis_tready && m_curr_axis_tready;
        fire_out = m_prev_axis_tvalid && both_rdy;
        mp = {m_prev_axis_tdata, m_prev_axis_tuser, m_prev_axis_tlast};
        mc = {m_curr_axis_tdata, m_curr_axis_tuser, m_curr_axis_tlast};
        chk("valid_pair", 64'(m_curr_axis_tvalid), 64'(m_prev_axis_tvalid));
        if (have_stall) begin
            chk("stall_valid", 64'(m_prev_axis_tvalid), 64'd1);
            chk("stall_prev", 64'(mp), 64'(snap_p));
            chk("stall_curr", 64'(mc), 64'(snap_c));
        end
        if (frame_locked) chk("pair_consume", 64'(p_acc), 64'(c_acc));
        if (frame_locked && m_prev_axis_tvalid && !both_rdy)
            chk("stall_s_ready", 64'({s_prev_axis_tready, s_curr_axis_tready}), 64'd0);
        have_stall = m_prev_axis_tvalid && !both_rdy;
        snap_p = mp;
        snap_c = mc;
        lock_log.push_back(frame_locked);
        pr_log.push_back(s_prev_axis_tready);
        if (fire_out) begin
            pr.p = mp; pr.c = mc;
            out_log.push_back(pr);
        end
        @(posedge clk);
        if (p_acc) begin void'(sp_q.pop_front()); p_pres = 1'b0; end
        if (c_acc) begin void'(sc_q.pop_front()); c_pres = 1'b0; end
        progress = p_acc || c_acc || fire_out;
        cyc_idx++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        aresetn = 1'b0;
        s_prev_axis_tvalid = 1'b0;
        s_curr_axis_tvalid = 1'b0;
        p_pres = 1'b0; c_pres = 1'b0;
        sp_q.delete(); sc_q.delete(); bp_pat.delete();
        have_stall = 1'b0;
        exp_err = 0;
        repeat (2) @(negedge clk);
        aresetn = 1'b1;
    endtask

    task automatic start_scn();
        out_log.delete(); exp_q.delete(); lock_log.delete(); pr_log.delete();
        cyc_idx = 0;
    endtask

    task automatic run_scn(input string name);
        int n, idle, m;
        mp_q = sp_q;
        mc_q = sc_q;
        model_run();
        n = 0; idle = 0;
        while (idle < 40 && n < 3000) begin
            cycle();
            n++;
            idle = progress ? 0 : idle + 1;
        end
        if (n >= 3000) begin
            checks++; failures++;
            $display("FAIL %s_timeout actual=no_idle required=idle_within_3000", name);
        end
        chk({name, "_out_count"}, 64'(out_log.size()), 64'(exp_q.size()));
        m = (out_log.size() < exp_q.size()) ? out_log.size() : exp_q.size();
        for (int i = 0; i < m; i++) begin
            chk({name, "_out_prev"}, 64'(out_log[i].p), 64'(exp_q[i].p));
            chk({name, "_out_curr"}, 64'(out_log[i].c), 64'(exp_q[i].c));
        end
        chk({name, "_err_count"}, 64'(err_count), 64'(exp_err));
        chk({name, "_err_sticky"}, 64'(err_sticky), 64'(exp_err > 0));
        $display("scenario %s cycles=%0d pairs=%0d errors=%0d", name, n, out_log.size(), err_count);
    endtask

    seek_vec_t tbl[4];

    initial begin
        #2_000_000;
        failures++;
        $display("FAIL watchdog actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int n;
        logic seen, dropped, relocked;
        tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

        // Reset state, with live non-SOF input beats that must not be accepted
        aresetn = 1'b0;
        s_prev_axis_tdata = 32'h1234; s_curr_axis_tdata = 32'h5678;
        s_prev_axis_tvalid = 1'b1; s_curr_axis_tvalid = 1'b1;
        s_prev_axis_tuser = 1'b0; s_curr_axis_tuser = 1'b0;
        s_prev_axis_tlast = 1'b0; s_curr_axis_tlast = 1'b0;
        m_prev_axis_tready = 1'b1; m_curr_axis_tready = 1'b1;
        #13;
        chk("rst_m_valid", 64'({m_prev_axis_tvalid, m_curr_axis_tvalid}), 64'd0);
        chk("rst_m_data", 64'({m_prev_axis_tdata, m_curr_axis_tdata}), 64'd0);
        chk("rst_m_flags", 64'({m_prev_axis_tlast, m_prev_axis_tuser, m_curr_axis_tlast, m_curr_axis_tuser}), 64'd0);
        chk("rst_s_ready", 64'({s_prev_axis_tready, s_curr_axis_tready}), 64'd0);
        chk("rst_status", 64'({frame_locked, err_sticky, err_count}), 64'd0);
        do_reset();

        // SEEK ready table: beats are withdrawn before the clock edge so state stays SEEK
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            s_prev_axis_tvalid = tbl[i].pv; s_prev_axis_tuser = tbl[i].pu;
            s_curr_axis_tvalid = tbl[i].cv; s_curr_axis_tuser = tbl[i].cu;
            #1;
            chk("seek_prev_ready", 64'(s_prev_axis_tready), 64'(tbl[i].exp_pr));
            chk("seek_curr_ready", 64'(s_curr_axis_tready), 64'(tbl[i].exp_cr));
            chk("seek_unlocked", 64'(frame_locked), 64'd0);
            #1;
            s_prev_axis_tvalid = 1'b0; s_curr_axis_tvalid = 1'b0;
        end

        // Aligned start
        do_reset(); start_scn();
        push_frame(0, H * V, -1); push_frame(1, H * V, -1);
        vpct = 100; rpct = 100;
        run_scn("aligned");
        chk("aligned_lock_c0", 64'(lock_log[0]), 64'd0);
        chk("aligned_lock_c1", 64'(lock_log[1]), 64'd1);
        chk("aligned_pairs", 64'(out_log.size()), 64'(H * V));
        if (out_log.size() > 7) chk("aligned_tlast_x7", 64'({out_log[7].p.last, out_log[7].c.last}), 64'd3);

        // Offset start: curr has 5 junk beats ahead of its SOF
        do_reset(); start_scn();
        push_frame(0, H * V, -1); push_junk(1, 5); push_frame(1, H * V, -1);
        run_scn("offset");
        chk("offset_prev_held", 64'(pr_log[0]), 64'd0);
        if (out_log.size() > 0) chk("offset_first_sof", 64'({out_log[0].p.user, out_log[0].c.user}), 64'd3);
        else chk("offset_first_sof", 64'(out_log.size()), 64'd1);

        // Backpressure on curr with pattern 1,0,0,1
        do_reset(); start_scn();
        push_frame(0, H * V, -1); push_frame(1, H * V, -1);
        bp_pat.push_back(1'b1); bp_pat.push_back(1'b0); bp_pat.push_back(1'b0); bp_pat.push_back(1'b1);
        run_scn("backpressure");
        chk("bp_pairs", 64'(out_log.size()), 64'(H * V));
        bp_pat.delete();

        // Short line on prev, then relock on the next dual SOF
        do_reset(); start_scn();
        push_frame(0, H * V, 5); push_frame(0, H * V, -1);
        push_frame(1, H * V, -1); push_frame(1, H * V, -1);
        run_scn("short_line");
        seen = 1'b0; dropped = 1'b0; relocked = 1'b0;
        foreach (lock_log[i]) begin
            if (lock_log[i] && dropped) relocked = 1'b1;
            if (!lock_log[i] && seen) dropped = 1'b1;
            if (lock_log[i]) seen = 1'b1;
        end
        chk("short_unlock", 64'(dropped), 64'd1);
        chk("short_relock", 64'(relocked), 64'd1);

        // Mid-frame SOF on curr at x=3,y=1
        do_reset(); start_scn();
        push_frame(0, H * V, -1); push_frame(0, H * V, -1);
        push_frame(1, H + 3, -1); push_frame(1, H * V, -1);
        run_scn("mid_sof");

        // Async reset mid-frame with a loaded output slot; no reset after the previous error
        start_scn();
        push_frame(0, H * V, -1); push_frame(0, H * V, -1);
        push_frame(1, H * V, -1); push_frame(1, H * V, -1);
        n = 0;
        while (out_log.size() < 20 && n < 200) begin cycle(); n++; end
        if (n >= 200) begin
            checks++; failures++;
            $display("FAIL arst_setup_timeout actual=%0d required=20", out_log.size());
        end
        @(negedge clk);
        m_prev_axis_tready = 1'b0; m_curr_axis_tready = 1'b0;
        #2;
        chk("pre_rst_valid", 64'(m_prev_axis_tvalid), 64'd1);
        chk("pre_rst_err", 64'({err_sticky, err_count}), 64'h10001);
        aresetn = 1'b0;
        #1;
        chk("arst_m_valid", 64'({m_prev_axis_tvalid, m_curr_axis_tvalid}), 64'd0);
        chk("arst_m_data", 64'({m_prev_axis_tdata, m_curr_axis_tdata}), 64'd0);
        chk("arst_err", 64'({err_sticky, err_count}), 64'd0);
        chk("arst_unlocked", 64'(frame_locked), 64'd0);
        chk("arst_s_ready", 64'({s_prev_axis_tready, s_curr_axis_tready}), 64'd0);
        do_reset(); start_scn();
        push_frame(0, H * V, -1); push_frame(1, H * V, -1);
        run_scn("after_arst");

        // Randomized streams: junk preambles, valid gaps, output stalls, occasional faults
        for (int r = 0; r < 10; r++) begin
            int pj, cj, kind, strm, idx;
            beat_t b;
            do_reset(); start_scn();
            vpct = $urandom_range(50, 100);
            rpct = $urandom_range(60, 100);
            pj = $urandom_range(0, 6); cj = $urandom_range(0, 6);
            push_junk(0, pj); push_frame(0, H * V, -1); push_frame(0, H * V, -1);
            push_junk(1, cj); push_frame(1, H * V, -1); push_frame(1, H * V, -1);
            kind = $urandom_range(0, 2);
            strm = $urandom_range(0, 1);
            idx = ((strm == 0) ? pj : cj) + $urandom_range(1, 2 * H * V - 1);
            if (kind != 0) begin
                b = (strm == 0) ? sp_q[idx] : sc_q[idx];
                if (kind == 1) b.last = ~b.last;
                else           b.user = 1'b1;
                if (strm == 0) sp_q[idx] = b;
                else           sc_q[idx] = b;
            end
            run_scn("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
